// File: rtl/irq_gateway.sv
// Interrupt gateway: synchronizes raw peripheral interrupt lines, detects edge or level
// events, and holds a per-line pending request until the controller's completion pulse.
module irq_gateway #(
  parameter int N_IRQ       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] edge_mode_i,
  input  logic [N_IRQ-1:0] int_fin_i,
  input  logic [N_IRQ-1:0] ovf_clr_i,
  output logic [N_IRQ-1:0] int_req_o,
  output logic [N_IRQ-1:0] ovf_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } line_state_e;

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] s_d_q;
  logic [N_IRQ-1:0] s_now;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] ovf_q, ovf_d, ovf_set;
  line_state_e      state_q [N_IRQ];
  line_state_e      state_d [N_IRQ];

  assign s_now = sync_q[SYNC_STAGES-1];
  // s_d_q resets to 0, so a line held high through reset produces exactly one rise.
  assign rise  = s_now & ~s_d_q;

  // NOTE: every register here, including the synchronizer array, is reset so that all
  // outputs are 0 immediately on rst_ni and no stale request survives a mid-run reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      for (int k = 0; k < N_IRQ; k++) state_q[k] <= IDLE;
      s_d_q <= '0;
      ovf_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value, which
      // is what turns this loop into a shift chain rather than a single wire.
      sync_q[0] <= irq_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      for (int k = 0; k < N_IRQ; k++) state_q[k] <= state_d[k];
      s_d_q <= s_now;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every variable and no latch is inferred.
    ovf_set = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      state_d[k] = state_q[k];
      if (edge_mode_i[k]) begin
        case (state_q[k])
          IDLE: if (rise[k]) state_d[k] = PEND;
          PEND: begin
            if (rise[k] && !int_fin_i[k]) ovf_set[k] = 1'b1;
            else if (int_fin_i[k] && !rise[k]) state_d[k] = IDLE;
          end
          ACK:     state_d[k] = rise[k] ? PEND : IDLE;
          default: state_d[k] = IDLE;
        endcase
      end else begin
        case (state_q[k])
          IDLE: if (s_now[k]) state_d[k] = PEND;
          PEND: if (int_fin_i[k]) state_d[k] = s_now[k] ? ACK : IDLE;
          // A level still held after completion is ignored until it drops.
          ACK:     if (!s_now[k]) state_d[k] = IDLE;
          default: state_d[k] = IDLE;
        endcase
      end
    end
    ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);
  end

  always_comb begin
    int_req_o = '0;
    for (int k = 0; k < N_IRQ; k++) int_req_o[k] = (state_q[k] == PEND);
  end

  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_irq_gateway.sv
// Directed bench for irq_gateway: reset, edge and level modes, overflow, async reset.
module tb_irq_gateway;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] irq_i, edge_mode_i, int_fin_i, ovf_clr_i;
  logic [31:0] int_req_o, ovf_o;

  int n_cmp = 0;
  int n_bad = 0;

  irq_gateway #(.N_IRQ(32), .SYNC_STAGES(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .irq_i       (irq_i),
    .edge_mode_i (edge_mode_i),
    .int_fin_i   (int_fin_i),
    .ovf_clr_i   (ovf_clr_i),
    .int_req_o   (int_req_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge; inputs and checks happen there.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // One-cycle pulse on irq_i bits, returning one edge after it was sampled.
  task automatic pulse_irq(input logic [31:0] bits);
    irq_i = irq_i | bits;
    tick();
    irq_i = irq_i & ~bits;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    irq_i = 32'hFFFF_FFFF;
    edge_mode_i = 32'hFFFF_FFFF;
    int_fin_i = '0;
    ovf_clr_i = '0;
    #3;
    n_cmp++;
    if (int_req_o !== 32'h0) begin
      n_bad++; $display("FAIL rst_req: got %h expected %h", int_req_o, 32'h0);
    end
    n_cmp++;
    if (ovf_o !== 32'h0) begin
      n_bad++; $display("FAIL rst_ovf: got %h expected %h", ovf_o, 32'h0);
    end
    tick(3);
    n_cmp++;
    if (int_req_o !== 32'h0) begin
      n_bad++; $display("FAIL rst_hold_req: got %h expected %h", int_req_o, 32'h0);
    end
    rst_ni = 1'b1;
    tick(2);
    n_cmp++;
    if (int_req_o !== 32'h0) begin
      n_bad++; $display("FAIL rst_early_req: got %h expected %h", int_req_o, 32'h0);
    end
    tick();
    n_cmp++;
    if (int_req_o !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL rst_rise_req: got %h expected %h", int_req_o, 32'hFFFF_FFFF);
    end
    tick(3);
    n_cmp++;
    if (int_req_o !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL rst_held_req: got %h expected %h", int_req_o, 32'hFFFF_FFFF);
    end
    int_fin_i = 32'hFFFF_FFFF;
    tick();
    int_fin_i = '0;
    irq_i = '0;
    n_cmp++;
    if (int_req_o !== 32'h0) begin
      n_bad++; $display("FAIL rst_fin_all: got %h expected %h", int_req_o, 32'h0);
    end
    tick(4);
    n_cmp++;
    if (int_req_o !== 32'h0 || ovf_o !== 32'h0) begin
      n_bad++; $display("FAIL rst_quiet: got req %h ovf %h expected 0 0", int_req_o, ovf_o);
    end
  endtask

  task automatic test_edge_single();
    pulse_irq(32'h8);
    tick();
    n_cmp++;
    if (int_req_o !== 32'h0) begin
      n_bad++; $display("FAIL edge_lat2: got %h expected %h", int_req_o, 32'h0);
    end
    tick();
    n_cmp++;
    if (int_req_o !== 32'h8) begin
      n_bad++; $display("FAIL edge_lat3: got %h expected %h", int_req_o, 32'h8);
    end
    tick(4);
    n_cmp++;
    if (int_req_o !== 32'h8) begin
      n_bad++; $display("FAIL edge_hold: got %h expected %h", int_req_o, 32'h8);
    end
    int_fin_i[3] = 1'b1;
    tick();
    int_fin_i = '0;
    n_cmp++;
    if (int_req_o !== 32'h0) begin
      n_bad++; $display("FAIL edge_fin: got %h expected %h", int_req_o, 32'h0);
    end
    tick(4);
    n_cmp++;
    if (int_req_o !== 32'h0 || ovf_o !== 32'h0) begin
      n_bad++; $display("FAIL edge_no_rereq: got req %h ovf %h expected 0 0", int_req_o, ovf_o);
    end
  endtask

  task automatic test_edge_overflow();
    pulse_irq(32'h20);
    tick(2);
    n_cmp++;
    if (int_req_o !== 32'h20) begin
      n_bad++; $display("FAIL ovf_first_req: got %h expected %h", int_req_o, 32'h20);
    end
    pulse_irq(32'h20);
    tick(2);
    n_cmp++;
    if (ovf_o !== 32'h20 || int_req_o !== 32'h20) begin
      n_bad++; $display("FAIL ovf_set: got ovf %h req %h expected 20 20", ovf_o, int_req_o);
    end
    // Clear lands in the same cycle as a fresh overflow: set must win.
    pulse_irq(32'h20);
    tick();
    ovf_clr_i[5] = 1'b1;
    tick();
    ovf_clr_i = '0;
    n_cmp++;
    if (ovf_o !== 32'h20) begin
      n_bad++; $display("FAIL ovf_set_wins: got %h expected %h", ovf_o, 32'h20);
    end
    ovf_clr_i[5] = 1'b1;
    tick();
    ovf_clr_i = '0;
    n_cmp++;
    if (ovf_o !== 32'h0 || int_req_o !== 32'h20) begin
      n_bad++; $display("FAIL ovf_clr: got ovf %h req %h expected 0 20", ovf_o, int_req_o);
    end
    // Rise coincident with completion keeps the request, no overflow.
    pulse_irq(32'h20);
    tick();
    int_fin_i[5] = 1'b1;
    tick();
    int_fin_i = '0;
    n_cmp++;
    if (int_req_o !== 32'h20 || ovf_o !== 32'h0) begin
      n_bad++; $display("FAIL ovf_collide: got req %h ovf %h expected 20 0", int_req_o, ovf_o);
    end
    int_fin_i[5] = 1'b1;
    tick();
    int_fin_i = '0;
    n_cmp++;
    if (int_req_o !== 32'h0) begin
      n_bad++; $display("FAIL ovf_final_fin: got %h expected %h", int_req_o, 32'h0);
    end
  endtask

  task automatic test_level_hold();
    edge_mode_i[0] = 1'b0;
    irq_i[0] = 1'b1;
    tick(2);
    n_cmp++;
    if (int_req_o !== 32'h0) begin
      n_bad++; $display("FAIL lvl_lat2: got %h expected %h", int_req_o, 32'h0);
    end
    tick();
    n_cmp++;
    if (int_req_o !== 32'h1) begin
      n_bad++; $display("FAIL lvl_lat3: got %h expected %h", int_req_o, 32'h1);
    end
    int_fin_i[0] = 1'b1;
    tick();
    int_fin_i = '0;
    n_cmp++;
    if (int_req_o !== 32'h0) begin
      n_bad++; $display("FAIL lvl_fin: got %h expected %h", int_req_o, 32'h0);
    end
    tick(5);
    n_cmp++;
    if (int_req_o !== 32'h0) begin
      n_bad++; $display("FAIL lvl_held_once: got %h expected %h", int_req_o, 32'h0);
    end
    irq_i[0] = 1'b0;
    tick(4);
    irq_i[0] = 1'b1;
    tick(2);
    n_cmp++;
    if (int_req_o !== 32'h0) begin
      n_bad++; $display("FAIL lvl_re_lat2: got %h expected %h", int_req_o, 32'h0);
    end
    tick();
    n_cmp++;
    if (int_req_o !== 32'h1 || ovf_o !== 32'h0) begin
      n_bad++; $display("FAIL lvl_re_req: got req %h ovf %h expected 1 0", int_req_o, ovf_o);
    end
    irq_i[0] = 1'b0;
    int_fin_i[0] = 1'b1;
    tick();
    int_fin_i = '0;
    tick(4);
    n_cmp++;
    if (int_req_o !== 32'h0) begin
      n_bad++; $display("FAIL lvl_release: got %h expected %h", int_req_o, 32'h0);
    end
    edge_mode_i = 32'hFFFF_FFFF;
  endtask

  task automatic test_async_reset();
    pulse_irq(32'h86);
    tick(2);
    pulse_irq(32'h04);
    tick(2);
    n_cmp++;
    if (int_req_o !== 32'h86 || ovf_o !== 32'h04) begin
      n_bad++; $display("FAIL arst_setup: got req %h ovf %h expected 86 04", int_req_o, ovf_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (int_req_o !== 32'h0 || ovf_o !== 32'h0) begin
      n_bad++; $display("FAIL arst_immediate: got req %h ovf %h expected 0 0", int_req_o, ovf_o);
    end
    #1;
    rst_ni = 1'b1;
    tick(4);
    n_cmp++;
    if (int_req_o !== 32'h0 || ovf_o !== 32'h0) begin
      n_bad++; $display("FAIL arst_after: got req %h ovf %h expected 0 0", int_req_o, ovf_o);
    end
  endtask

  initial begin
    test_reset();
    test_edge_single();
    test_edge_overflow();
    test_level_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
